// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (RV32M DIV/DIVU/REM/REMU) with ready/valid writeback.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iteration loop.
module div_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] src0,
   input  logic [DATA_WIDTH-1:0] src1,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  kill,
   output logic                  busy,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic                  wb_we,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [1:0]            dbg_state
);

   // Handshakes: a request transfers on a rising edge where in_valid & in_ready & !kill;
   // a result transfers on a rising edge where wb_valid & wb_ready & !kill.

   localparam int W  = DATA_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   logic [1:0]            state_q;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [W-1:0]          divisor_q;
   logic [W-1:0]          rem_q;
   logic [W-1:0]          quo_q;
   logic [CW-1:0]         cnt_q;
   logic                  a_neg_q;
   logic                  b_neg_q;
   logic                  div0_q;
   logic                  ovf_q;
   logic [W-1:0]          wb_data_q;

   // Operand conditioning at accept time
   logic          in_signed;
   logic          src0_neg;
   logic          src1_neg;
   logic [W-1:0]  abs0;
   logic [W-1:0]  abs1;
   logic          in_div0;
   logic          in_ovf;

   assign in_signed = ~op[0];
   assign src0_neg  = in_signed & src0[W-1];
   assign src1_neg  = in_signed & src1[W-1];
   assign abs0      = src0_neg ? (-src0) : src0;
   assign abs1      = src1_neg ? (-src1) : src1;
   assign in_div0   = (src1 == '0);
   assign in_ovf    = in_signed & (src0 == MIN_NEG) & (src1 == '1);

   // One restoring step; the extra top bit keeps the compare exact when rem exceeds 2^(W-1)
   logic [W:0] rem_ext;
   logic [W:0] diff;
   logic       step_ge;

   assign rem_ext = {rem_q, quo_q[W-1]};
   assign diff    = rem_ext - {1'b0, divisor_q};
   assign step_ge = ~diff[W];

   // Sign correction and forced special-case results
   logic [W-1:0] quo_fix;
   logic [W-1:0] rem_fix;
   logic [W-1:0] fix_result;

   always_comb begin
      quo_fix = (a_neg_q ^ b_neg_q) ? (-quo_q) : quo_q;
      rem_fix = a_neg_q ? (-rem_q) : rem_q;
      if (div0_q) begin
         quo_fix = '1;
      end
      if (ovf_q) begin
         quo_fix = MIN_NEG;
         rem_fix = '0;
      end
      fix_result = op_q[1] ? rem_fix : quo_fix;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         divisor_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         a_neg_q   <= 1'b0;
         b_neg_q   <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wb_data_q <= '0;
      end else if (kill && (state_q != S_IDLE)) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && !kill) begin
                  state_q   <= S_CALC;
                  op_q      <= op;
                  addr_q    <= rd_addr;
                  divisor_q <= abs1;
                  rem_q     <= '0;
                  quo_q     <= abs0;
                  cnt_q     <= CW'(W - 1);
                  a_neg_q   <= src0_neg;
                  b_neg_q   <= src1_neg;
                  div0_q    <= in_div0;
                  ovf_q     <= in_ovf;
`ifdef DIV_FAST_SPECIAL_EN
                  // FIX only needs |dividend| in rem for the divide-by-zero remainder
                  if (in_div0 || in_ovf) begin
                     state_q <= S_FIX;
                     rem_q   <= abs0;
                  end
`endif
               end
            end
            S_CALC: begin
               rem_q <= step_ge ? diff[W-1:0] : rem_ext[W-1:0];
               quo_q <= {quo_q[W-2:0], step_ge};
               if (cnt_q == '0) begin
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_FIX: begin
               wb_data_q <= fix_result;
               state_q   <= S_DONE;
            end
            S_DONE: begin
               if (wb_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign wb_valid  = (state_q == S_DONE);
   assign wb_addr   = addr_q;
   assign wb_data   = wb_data_q;
   assign wb_we     = wb_valid & wb_ready & ~kill & (addr_q != '0);
   assign dbg_state = state_q;

endmodule
